opc5_mem_arbiter: RTL and testbench
===================================

// Module: opc5_mem_arbiter
//
// PURPOSE
// Two-master arbiter/sequencer for the shared 64K x 16 asynchronous SRAM of the
// OPC5 system. Master 0 is the CPU, master 1 a DMA/loader port. It serialises
// req/ack transactions onto the single SRAM port, generating ceb/oeb/web strobes.
// CPU has fixed priority, with a starvation counter guaranteeing master 1 progress.
//
// PARAMETERS
// AW         16  address width (words)
// DW         16  data width
// STARVE_MAX 3   consecutive m0 grants allowed while m1 waits (legal 1..15)
//
// PORTS
// clk        in   1   system clock, all state on rising edge
// reset_b    in   1   asynchronous, active-low reset
// m0_req     in   1   master 0 request; hold with m0_rnw/addr/wdata stable until ack
// m0_rnw     in   1   1 = read, 0 = write
// m0_addr    in   AW  word address
// m0_wdata   in   DW  write data
// m0_ack     out  1   one-cycle completion pulse
// m0_rdata   out  DW  read data, valid in ack cycle, held until next m0 read
// m1_*       --   --  identical set for master 1 (req, rnw, addr, wdata, ack, rdata)
// mem_addr   out  AW  SRAM address
// mem_wdata  out  DW  SRAM write data (tri-state buffer at top level, enabled by !web)
// mem_rdata  in   DW  SRAM read data
// mem_ceb    out  1   chip enable, active low
// mem_oeb    out  1   output enable, active low
// mem_web    out  1   write enable, active low
// busy       out  1   high in ACCESS and DONE
//
// BEHAVIOUR
// - Reset (async): state IDLE, starve count 0; m*_ack 0, m*_rdata 0, mem_addr 0,
//   mem_wdata 0, mem_ceb/oeb/web 1, busy 0. Reset mid-transaction aborts it: strobes
//   deassert immediately, no ack ever issued for the aborted access.
// - FSM IDLE -> ACCESS -> DONE -> IDLE; one access per 3 cycles max.
// - IDLE: if any req, choose winner, register its addr/wdata/rnw onto mem_* outputs,
//   go ACCESS. No req: stay, strobes inactive.
// - ACCESS (1 cycle): mem_ceb=0; read: mem_oeb=0, web=1; write: mem_web=0, oeb=1.
//   At end of ACCESS, read data captured from mem_rdata into winner's rdata.
// - DONE: all strobes 1; winner's ack=1 for exactly this cycle. Master must drop or
//   renew req by next edge; req is only re-sampled in IDLE, so a req still high in
//   IDLE is a new transaction.
// - Latency: req seen in IDLE cycle N -> ACCESS N+1 -> ack N+2.
// - Arbitration (IDLE only): only m0 -> m0; only m1 -> m1; both -> m0 unless
//   starve count == STARVE_MAX, then m1.
// - Starve count (4 bits): +1 on m0 grant when m1_req=1 at that arbitration;
//   cleared on m1 grant or on m0 grant with m1_req=0. Never exceeds STARVE_MAX.
// - Requests arriving during ACCESS/DONE wait; never dropped, never preempt.
// - Only winner's ack/rdata change; loser's rdata holds.
// - Address/data widths pass through unmodified; no wrap logic (full AW space).
//
// TESTING
// 1. mem[0x1234]=0xBEEF; m0 read 0x1234 -> mem_ceb/oeb low 1 cycle, m0_ack 2 cycles
//    after req sampled, m0_rdata=0xBEEF, m1 outputs unchanged.
// 2. m1 write 0x0010 <- 0xA5A5 -> mem_web low exactly 1 cycle with addr 0x0010,
//    m1_ack pulses; m0 read 0x0010 then returns 0xA5A5.
// 3. Both masters re-request continuously, STARVE_MAX=3 -> grant order
//    m0,m0,m0,m1,m0,m0,m0,m1; one ack every 3 cycles.
// 4. m0 req rises while m1 in ACCESS -> m1 completes with ack, m0 granted in
//    following IDLE, m0_ack 3 cycles after m1_ack.
// 5. reset_b low in ACCESS of a write -> ceb/web go 1 asynchronously, no ack;
//    after release all outputs at reset values, next req served normally.
// 6. m1 only, req held high 10 accesses -> 10 m1 acks spaced 3 cycles, starve
//    count stays 0, m0_ack never asserts.

Source files
------------

// File: rtl/opc5_mem_arbiter.sv
// ---------------------------------------------------------------------------
// opc5_mem_arbiter
// Two-master arbiter/sequencer for the shared 64K x 16 asynchronous SRAM.
// Master 0 (CPU) has fixed priority. A starvation counter guarantees that
// master 1 (DMA/loader) makes progress. Each access takes three cycles:
// IDLE (arbitrate) -> ACCESS (strobes low) -> DONE (ack).
//
// Ports:
//   clk, reset_b                 clock, asynchronous active-low reset
//   m0_req/rnw/addr/wdata        master 0 request, held stable until m0_ack
//   m0_ack, m0_rdata             one-cycle completion, read data (held)
//   m1_*                         identical set for master 1
//   mem_addr, mem_wdata          SRAM address / write data (registered)
//   mem_rdata                    SRAM read data, captured at end of ACCESS
//   mem_ceb/oeb/web              active-low SRAM strobes (registered)
//   busy                         high in ACCESS and DONE
// ---------------------------------------------------------------------------
module opc5_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 3   // legal 1..15, fits the 4-bit counter
) (
  input  logic          clk,
  input  logic          reset_b,
  // master 0 (CPU)
  input  logic          m0_req,
  input  logic          m0_rnw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  // master 1 (DMA / loader)
  input  logic          m1_req,
  input  logic          m1_rnw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  // SRAM port
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_ceb,
  output logic          mem_oeb,
  output logic          mem_web,
  output logic          busy
);

  // Purpose: serialise two req/ack masters onto one async SRAM port.
  // Latency: req sampled in IDLE cycle N, strobes low in N+1, ack in N+2.
  // Backpressure: a request is held by its master until ack; no preemption.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_q,  state_d;
  logic [3:0]    starve_q, starve_d;
  logic          winner_q, winner_d;   // 0 = master 0, 1 = master 1
  logic          rnw_q,    rnw_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic          ceb_q,    ceb_d;
  logic          oeb_q,    oeb_d;
  logic          web_q,    web_d;
  logic          ack0_q,   ack0_d;
  logic          ack1_q,   ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic any_req;
  logic grant_m1;

  assign any_req = m0_req | m1_req;

  // Master 0 wins any contested arbitration unless master 1 has already
  // watched STARVE_LIM consecutive master-0 grants go past it.
  assign grant_m1 = m1_req & (~m0_req | (starve_q == STARVE_LIM));

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    winner_d = winner_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ceb_d    = 1'b1;
    oeb_d    = 1'b1;
    web_d    = 1'b1;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          winner_d = grant_m1;
          rnw_d    = grant_m1 ? m1_rnw   : m0_rnw;
          addr_d   = grant_m1 ? m1_addr  : m0_addr;
          wdata_d  = grant_m1 ? m1_wdata : m0_wdata;
          // The counter only advances while master 1 is actually waiting;
          // an uncontested master-0 grant means nobody is starving.
          if (grant_m1) begin
            starve_d = 4'd0;
          end else if (m1_req) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
          // Strobes are registered so they are low for exactly the ACCESS
          // cycle and drop straight back to inactive on async reset.
          ceb_d   = 1'b0;
          oeb_d   = ~rnw_d;
          web_d   = rnw_d;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // SRAM output has had the whole ACCESS cycle to settle.
        if (rnw_q) begin
          if (winner_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
        ack0_d  = ~winner_q;
        ack1_d  = winner_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Requests are not looked at here: a req still high once back in
        // IDLE is treated as a fresh transaction.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
      winner_q <= 1'b0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      ceb_q    <= 1'b1;
      oeb_q    <= 1'b1;
      web_q    <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      winner_q <= winner_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ceb_q    <= ceb_d;
      oeb_q    <= oeb_d;
      web_q    <= web_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ceb   = ceb_q;
  assign mem_oeb   = oeb_q;
  assign mem_web   = web_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_opc5_mem_arbiter
// Bench for opc5_mem_arbiter: SRAM behavioural model, directed scenarios and
// a randomized two-master run checked against a slot-based reference model.
// ---------------------------------------------------------------------------
module tb_opc5_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 3;

  logic          clk;
  logic          reset_b;
  logic          m0_req, m0_rnw, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_rnw, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ceb, mem_oeb, mem_web, busy;

  int tests;
  int failed;

  // SRAM model and the bench's own shadow copy of the expected contents
  logic [DW-1:0] sram   [65536];
  logic [DW-1:0] shadow [65536];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_dat;

  opc5_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_b(reset_b),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ceb(mem_ceb), .mem_oeb(mem_oeb), .mem_web(mem_web), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_dat;
    else if (!mem_ceb && !mem_web) sram[mem_addr] <= mem_wdata;
  end

  // Junk value when not output-enabled so a mistimed capture is visible
  assign mem_rdata = (!mem_ceb && !mem_oeb) ? sram[mem_addr] : 16'hDEAD;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_dat = d; pre_we = 1'b1;
    shadow[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      #1;
      tests++;
      if ({m0_ack, m1_ack, mem_ceb, mem_oeb, mem_web, busy} !== 6'b001110) begin
        failed++;
        $display("FAIL reset_ctl ph=%0d got=%b exp=001110", ph,
                 {m0_ack, m1_ack, mem_ceb, mem_oeb, mem_web, busy});
      end
      tests++;
      if ({m0_rdata, m1_rdata} !== 32'h0) begin
        failed++; $display("FAIL reset_rdata ph=%0d got=%h exp=0", ph, {m0_rdata, m1_rdata});
      end
      tests++;
      if ({mem_addr, mem_wdata} !== 32'h0) begin
        failed++; $display("FAIL reset_mem ph=%0d got=%h exp=0", ph, {mem_addr, mem_wdata});
      end
      if (ph == 0) begin
        @(negedge clk); reset_b = 1'b1; @(negedge clk);
      end
    end
  endtask

  task automatic test_read_m0();
    m0_rnw = 1'b1; m0_addr = 16'h1234; m0_wdata = 16'h0; m0_req = 1'b1;
    @(negedge clk);  // ACCESS
    tests++;
    if ({mem_ceb, mem_oeb, mem_web, m0_ack} !== 4'b0010 || mem_addr !== 16'h1234) begin
      failed++; $display("FAIL rd0_access got=%b/%h exp=0010/1234",
                         {mem_ceb, mem_oeb, mem_web, m0_ack}, mem_addr);
    end
    @(negedge clk);  // DONE
    tests++;
    if (m0_ack !== 1'b1 || m0_rdata !== 16'hBEEF) begin
      failed++; $display("FAIL rd0_ack got=%b/%h exp=1/beef", m0_ack, m0_rdata);
    end
    tests++;
    if (m1_ack !== 1'b0 || m1_rdata !== 16'h0 || {mem_ceb, mem_oeb, mem_web} !== 3'b111) begin
      failed++; $display("FAIL rd0_other got=%b/%h/%b exp=0/0000/111",
                         m1_ack, m1_rdata, {mem_ceb, mem_oeb, mem_web});
    end
    m0_req = 1'b0;
    @(negedge clk);
    tests++;
    if (m0_ack !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL rd0_after got=%b%b exp=00", m0_ack, busy);
    end
  endtask

  task automatic test_write_m1();
    m1_rnw = 1'b0; m1_addr = 16'h0010; m1_wdata = 16'hA5A5; m1_req = 1'b1;
    @(negedge clk);  // ACCESS
    tests++;
    if ({mem_ceb, mem_oeb, mem_web} !== 3'b010 || mem_addr !== 16'h0010 || mem_wdata !== 16'hA5A5) begin
      failed++; $display("FAIL wr1_access got=%b/%h/%h exp=010/0010/a5a5",
                         {mem_ceb, mem_oeb, mem_web}, mem_addr, mem_wdata);
    end
    @(negedge clk);  // DONE
    tests++;
    if ({m0_ack, m1_ack, mem_web} !== 3'b011 || m1_rdata !== 16'h0) begin
      failed++; $display("FAIL wr1_done got=%b/%h exp=011/0000", {m0_ack, m1_ack, mem_web}, m1_rdata);
    end
    m1_req = 1'b0;
    shadow[16'h0010] = 16'hA5A5;
    @(negedge clk);
    m0_rnw = 1'b1; m0_addr = 16'h0010; m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (m0_ack !== 1'b1 || m0_rdata !== 16'hA5A5) begin
      failed++; $display("FAIL wr1_readback got=%b/%h exp=1/a5a5", m0_ack, m0_rdata);
    end
    m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [1:0] exp_ack;
    int idx;
    m0_rnw = 1'b1; m0_addr = 16'h0001; m1_rnw = 1'b1; m1_addr = 16'h0002;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      idx = k / 3;
      if (k % 3 == 1) exp_ack = ((idx % (SM + 1)) == SM) ? 2'b01 : 2'b10;
      else            exp_ack = 2'b00;
      tests++;
      if ({m0_ack, m1_ack} !== exp_ack) begin
        failed++; $display("FAIL starve_order k=%0d got=%b exp=%b", k, {m0_ack, m1_ack}, exp_ack);
      end
      if (exp_ack == 2'b01) begin
        tests++;
        if (m1_rdata !== shadow[16'h0002]) begin
          failed++; $display("FAIL starve_rd1 k=%0d got=%h exp=%h", k, m1_rdata, shadow[16'h0002]);
        end
      end
      if (k == 22) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
  endtask

  task automatic test_late_req();
    m1_rnw = 1'b1; m1_addr = 16'h0003; m1_req = 1'b1;
    @(negedge clk);  // m1 ACCESS
    m0_rnw = 1'b1; m0_addr = 16'h0004; m0_req = 1'b1;
    @(negedge clk);  // m1 DONE
    tests++;
    if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== shadow[16'h0003]) begin
      failed++; $display("FAIL late_m1 got=%b/%h exp=01/%h", {m0_ack, m1_ack}, m1_rdata, shadow[16'h0003]);
    end
    m1_req = 1'b0;
    @(negedge clk);  // IDLE
    tests++;
    if ({m0_ack, m1_ack, busy} !== 3'b000) begin
      failed++; $display("FAIL late_idle got=%b exp=000", {m0_ack, m1_ack, busy});
    end
    @(negedge clk);  // m0 ACCESS
    tests++;
    if (mem_ceb !== 1'b0 || mem_addr !== 16'h0004) begin
      failed++; $display("FAIL late_access got=%b/%h exp=0/0004", mem_ceb, mem_addr);
    end
    @(negedge clk);  // m0 DONE, 3 cycles after m1_ack
    tests++;
    if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== shadow[16'h0004]) begin
      failed++; $display("FAIL late_m0 got=%b/%h exp=10/%h", {m0_ack, m1_ack}, m0_rdata, shadow[16'h0004]);
    end
    m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    m0_rnw = 1'b0; m0_addr = 16'h0077; m0_wdata = 16'h1111; m0_req = 1'b1;
    @(negedge clk);  // ACCESS of write
    tests++;
    if (mem_web !== 1'b0) begin
      failed++; $display("FAIL rstmid_pre got web=%b exp=0", mem_web);
    end
    reset_b = 1'b0;
    #1;
    tests++;
    if ({mem_ceb, mem_oeb, mem_web, busy} !== 4'b1110 || {mem_addr, mem_wdata} !== 32'h0
        || {m0_rdata, m1_rdata} !== 32'h0) begin
      failed++; $display("FAIL rstmid_async got=%b/%h/%h exp=1110/0/0",
                         {mem_ceb, mem_oeb, mem_web, busy}, {mem_addr, mem_wdata}, {m0_rdata, m1_rdata});
    end
    m0_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) reset_b = 1'b1;
      @(negedge clk);
      tests++;
      if ({m0_ack, m1_ack, mem_ceb, mem_web} !== 4'b0011) begin
        failed++; $display("FAIL rstmid_noack k=%0d got=%b exp=0011", k, {m0_ack, m1_ack, mem_ceb, mem_web});
      end
    end
    m1_rnw = 1'b1; m1_addr = 16'h0077; m1_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (m1_ack !== 1'b1 || m1_rdata !== 16'h7777) begin
      failed++; $display("FAIL rstmid_after got=%b/%h exp=1/7777", m1_ack, m1_rdata);
    end
    m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_m1_stream();
    int acks;
    logic [1:0] exp_ack;
    acks = 0;
    m1_rnw = 1'b1; m1_addr = 16'h0100; m1_req = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      exp_ack = (k % 3 == 1) ? 2'b01 : 2'b00;
      tests++;
      if ({m0_ack, m1_ack} !== exp_ack) begin
        failed++; $display("FAIL stream_ack k=%0d got=%b exp=%b", k, {m0_ack, m1_ack}, exp_ack);
      end
      if (m1_ack === 1'b1) begin
        acks++;
        tests++;
        if (m1_rdata !== 16'hC0DE) begin
          failed++; $display("FAIL stream_rd k=%0d got=%h exp=c0de", k, m1_rdata);
        end
      end
      if (k == 28) m1_req = 1'b0;
    end
    tests++;
    if (acks != 10) begin
      failed++; $display("FAIL stream_count got=%0d exp=10", acks);
    end
  endtask

  // Reference model: the SRAM port is a sequence of 3-cycle slots. A slot
  // opens whenever no earlier slot is still in flight and someone requests.
  task automatic test_random();
    int            free_at, starve, pc;
    bit            pv, pw, prnw, in_acc, in_done;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd, pr, erd0, erd1;
    logic [2:0]    exp_strb;
    logic [1:0]    exp_ack;
    free_at = 0; starve = 0; pv = 1'b0; pc = 0; pw = 1'b0; prnw = 1'b1;
    pa = '0; pd = '0; pr = '0; erd0 = '0; erd1 = '0;
    m0_req = 1'b0; m1_req = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    for (int cy = 0; cy < 900; cy++) begin
      @(negedge clk);
      in_acc  = pv && (cy == pc + 1);
      in_done = pv && (cy == pc + 2);
      exp_strb = {~in_acc, ~(in_acc & prnw), ~(in_acc & ~prnw)};
      tests++;
      if ({mem_ceb, mem_oeb, mem_web} !== exp_strb) begin
        failed++; $display("FAIL rand_strobe cy=%0d got=%b exp=%b", cy, {mem_ceb, mem_oeb, mem_web}, exp_strb);
      end
      if (in_acc) begin
        tests++;
        if (mem_addr !== pa || (!prnw && mem_wdata !== pd)) begin
          failed++; $display("FAIL rand_addr cy=%0d got=%h/%h exp=%h/%h", cy, mem_addr, mem_wdata, pa, pd);
        end
      end
      if (in_done && prnw) begin
        if (pw) erd1 = pr; else erd0 = pr;
      end
      exp_ack = {in_done & ~pw, in_done & pw};
      tests++;
      if ({m0_ack, m1_ack} !== exp_ack || busy !== (in_acc | in_done)) begin
        failed++; $display("FAIL rand_ack cy=%0d got=%b/%b exp=%b/%b", cy, {m0_ack, m1_ack}, busy,
                           exp_ack, in_acc | in_done);
      end
      tests++;
      if (m0_rdata !== erd0 || m1_rdata !== erd1) begin
        failed++; $display("FAIL rand_rdata cy=%0d got=%h/%h exp=%h/%h", cy, m0_rdata, m1_rdata, erd0, erd1);
      end
      if (in_done) pv = 1'b0;

      // Masters: raise when idle, and on ack either renew or drop
      if ((!m0_req && $urandom_range(0, 2) == 0) || (m0_req && m0_ack === 1'b1)) begin
        m0_req   = !m0_req || ($urandom_range(0, 3) != 0);
        m0_rnw   = 1'($urandom_range(0, 1));
        m0_addr  = 16'($urandom_range(0, 15));
        m0_wdata = 16'($urandom);
      end
      if ((!m1_req && $urandom_range(0, 1) == 0) || (m1_req && m1_ack === 1'b1)) begin
        m1_req   = !m1_req || ($urandom_range(0, 3) != 0);
        m1_rnw   = 1'($urandom_range(0, 1));
        m1_addr  = 16'($urandom_range(0, 15));
        m1_wdata = 16'($urandom);
      end

      if (cy >= free_at && (m0_req || m1_req)) begin
        pw = m1_req && (!m0_req || starve == SM);
        if (pw || !m1_req) starve = 0;
        else               starve = starve + 1;
        pv = 1'b1; pc = cy; free_at = cy + 3;
        prnw = pw ? m1_rnw   : m0_rnw;
        pa   = pw ? m1_addr  : m0_addr;
        pd   = pw ? m1_wdata : m0_wdata;
        if (prnw) pr = shadow[pa];
        else      shadow[pa] = pd;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tests = 0; failed = 0;
    reset_b = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    m0_req = 1'b0; m0_rnw = 1'b1; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_rnw = 1'b1; m1_addr = '0; m1_wdata = '0;
    @(negedge clk);
    for (int a = 0; a < 16; a++) preload(16'(a), 16'($urandom));
    preload(16'h1234, 16'hBEEF);
    preload(16'h0010, 16'h0F0F);
    preload(16'h0077, 16'h7777);
    preload(16'h0100, 16'hC0DE);
    test_reset();
    test_read_m0();
    test_write_m1();
    test_starvation();
    test_late_req();
    test_reset_mid_access();
    test_m1_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
